pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
Parametrised successor to the fixed EX/MEM latch: one pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer, so the upstream `in_ready` comes straight from a flop.
- Carries a control bundle (MemtoReg/RegWrite/MemRead/MemWrite/Jump-style bits) plus a data payload (`result`, operands, fields).
- Adds synchronous flush, which inserts a bubble with control bits forced to zero.
- Instantiated between the EX, MEM and WB stages of the 6-stage pipeline.

Parameters:
- DATA_W, 140, payload width in bits (result, operands, immediate, address, fields).
- CTRL_W, 5, control bundle width; every bit is cleared on flush and bubble.
- CNT_W, 16, statistics counter width (used only with STAT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  block can accept an entry; driven directly from a flop.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bits of the head entry; 0 whenever out_valid=0.
- out_data  out  DATA_W  payload of the head entry.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, skid registers=0, in_ready=1, occupancy=0. Reset asserted mid-transfer discards everything.
- Events: push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: the main register drives the outputs; the skid register holds the overflow entry.
- State machine (encoded EMPTY=0, ONE=1, FULL=2; occupancy equals the state):
  - EMPTY: push -> ONE, main loads in_*.
  - ONE, push & pop -> ONE, main loads in_*.
  - ONE, push & no pop -> FULL, skid loads in_*.
  - ONE, pop & no push -> EMPTY, main ctrl cleared to 0 (data held).
  - ONE, no push & no pop -> ONE, hold.
  - FULL: in_ready=0, so no push is possible. Pop -> ONE, main loads skid. No pop -> FULL, hold.
- in_ready is a registered value: its next value is 1 unless the next state is FULL.
- Latency: 1 cycle from a push in EMPTY to out_valid=1.
- Throughput: 1 entry per cycle while out_ready stays high. The skid entry is used only on a downstream stall.
- out_data, out_ctrl and out_valid are stable while out_valid=1 and out_ready=0.
- Flush has highest priority:
  - Next state EMPTY; all valids 0; main and skid ctrl cleared to 0; data registers unchanged; in_ready=1 next cycle.
  - A push in the same cycle is dropped. A pop in the same cycle still counts downstream (the entry was presented).
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.

Optional Feature:
STAT_EN.
- Defined: adds ports stat_clr (in, 1), stall_cnt (out, CNT_W) and bubble_cnt (out, CNT_W).
  - stall_cnt increments on cycles with out_valid & ~out_ready.
  - bubble_cnt increments on cycles with ~out_valid.
  - Both counters saturate at all-ones, reset to 0, and are cleared synchronously by stat_clr. stat_clr takes priority over the increment.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - control-bit index constants: CTRL_MEMTOREG=0, CTRL_REGWRITE=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_JUMP=4;
  - the state encoding constants EMPTY/ONE/FULL;
  - the default DATA_W/CTRL_W values.
- One sub-module: sat_cnt (saturating counter with sync clear), instantiated twice, only under STAT_EN. The core is a single module.

Test Plan:
1. Release reset, hold out_ready=1, push 4 entries back-to-back (data 0x1..0x4, ctrl 5'b00011) -> out_valid rises 1 cycle after the first push; outputs 0x1..0x4 on consecutive cycles; in_ready stays 1; occupancy stays ≤1.
2. Fill to FULL with out_ready=0 (push 0xA then 0xB) -> occupancy=2 and in_ready=0 on the next cycle; out_data holds 0xA. Raise out_ready -> 0xA, then 0xB; in_ready returns to 1 after the first pop.
3. Assert flush in FULL together with in_valid (data 0xC) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xC never appears at the output.
4. Assert rst=0 asynchronously mid-cycle while in state ONE with ctrl 5'b11111 -> out_valid and out_ctrl go to 0 immediately, without waiting for a clock edge.
5. Random in_valid/out_ready (10k cycles) against a scoreboard -> no loss, duplication or reordering; out_ctrl=0 whenever out_valid=0.
6. STAT_EN, CNT_W=4: stall the output for 20 cycles -> stall_cnt saturates at 15; pulse stat_clr -> 0 the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: control-bit indices,
// skid-register state encoding and default widths.
package pipe_pkg;

  localparam int unsigned CTRL_MEMTOREG = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_JUMP     = 4;

  localparam int unsigned PIPE_DATA_W = 140;
  localparam int unsigned PIPE_CTRL_W = CTRL_JUMP + 1;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Occupancy of the stage register; the encoding is the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_sat_cnt.sv
// Saturating up-counter with synchronous clear; exists only when STAT_EN is defined.
`ifdef STAT_EN
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional STAT_EN macro adds stall/bubble statistics counters.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
`ifdef STAT_EN
  parameter int unsigned CNT_W  = PIPE_CNT_W,
`endif
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef STAT_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  skid_state_e       r_state;
  skid_state_e       w_nxt_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_push;
  logic w_pop;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_main_clr;
  logic w_skid_ld;
  logic w_clr_all;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state and datapath load strobes; flush overrides every transfer.
  always_comb begin
    w_nxt_state    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    w_clr_all      = 1'b0;
    if (flush) begin
      w_nxt_state = EMPTY;
      w_clr_all   = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_nxt_state  = ONE;
            w_main_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_ld_in = 1'b1;
          end else if (w_push) begin
            w_nxt_state = FULL;
            w_skid_ld   = 1'b1;
          end else if (w_pop) begin
            w_nxt_state = EMPTY;
            w_main_clr  = 1'b1;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_nxt_state    = ONE;
            w_main_ld_skid = 1'b1;
          end
        end
        default: begin
          w_nxt_state = EMPTY;
          w_clr_all   = 1'b1;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so in_ready leaves a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_nxt_state != FULL);
      r_out_valid <= (w_nxt_state != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (w_clr_all || w_main_clr) begin
      r_main_ctrl <= '0;
    end else if (w_main_ld_in) begin
      r_main_ctrl <= in_ctrl;
      r_main_data <= in_data;
    end else if (w_main_ld_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_clr_all) begin
      r_skid_ctrl <= '0;
    end else if (w_skid_ld) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = 2'(r_state);

`ifdef STAT_EN
  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (stat_clr),
    .i_inc (r_out_valid & ~out_ready),
    .o_cnt (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (stat_clr),
    .i_inc (~r_out_valid),
    .o_cnt (bubble_cnt)
  );
`endif

endmodule
